// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular exponentiator.
// Holds the FSM encodings used by the top and the Blakely multiplier.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQR,
    MUL,
    FIN
  } rsa_state_t;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } mm_state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int RSA_PUBLIC_E  = 65537;

endpackage

// File: rtl/rsa_modexp_mulmod.sv
// Radix-2 Blakely modular multiplier, one multiplier bit per cycle.
// p = a*b mod n, valid with done at WIDTH+1 cycles after start.
module blakely_mulmod
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = WIDTH + 2;

  mm_state_t      st_q, st_d;
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [RW-1:0]  r_q, r_d;
  logic [RW-1:0]  t1, t2, n_ext;
  logic [CW-1:0]  cnt_q;
  logic           accept;

  assign accept = start && (st_q != MM_RUN);
  assign done   = (st_q == MM_DONE);
  assign p      = r_q[WIDTH-1:0];
  assign n_ext  = {2'b00, n_q};

  // One Blakely step: shift-add then up to two conditional subtracts
  always_comb begin
    t1 = {r_q[RW-2:0], 1'b0};
    if (a_q[WIDTH-1]) t1 = t1 + {2'b00, b_q};
    t2 = (t1 >= n_ext) ? t1 - n_ext : t1;
    r_d = (t2 >= n_ext) ? t2 - n_ext : t2;
  end

  // Next-state: accept from idle or done, run WIDTH steps, then flag done
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      MM_IDLE: if (start) st_d = MM_RUN;
      MM_RUN:  if (cnt_q == '0) st_d = MM_DONE;
      MM_DONE: st_d = start ? MM_RUN : MM_IDLE;
      default: st_d = MM_IDLE;
    endcase
  end

  // State, operand capture and iteration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= MM_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        n_q   <= n;
        r_q   <= '0;
        cnt_q <= CW'(WIDTH - 1);
      end else if (st_q == MM_RUN) begin
        r_q   <= r_d;
        a_q   <= {a_q[WIDTH-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiator.
// Each square/multiply runs on a shared Blakely multiplier.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  rsa_state_t st_q, st_d;

  logic [WIDTH-1:0]     base_q, mod_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IW-1:0]        idx_q;

  logic             mm_start, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p, acc_init;
  logic             idx_dec, set_res, set_err, capture;

  assign capture  = (st_q == IDLE) && start;
  assign acc_init = WIDTH'(mod_q != WIDTH'(1));
  assign busy     = (st_q == LOAD) || (st_q == SQR) || (st_q == MUL);
  assign done     = (st_q == FIN);

  blakely_mulmod #(
    .WIDTH(WIDTH)
  ) u_mm (
    .clk  (clk),
    .reset(reset),
    .start(mm_start),
    .a    (mm_a),
    .b    (mm_b),
    .n    (mod_q),
    .done (mm_done),
    .p    (mm_p)
  );

  // Sequencing: next op is issued in the cycle the previous one completes
  always_comb begin
    st_d     = st_q;
    mm_start = 1'b0;
    mm_a     = mm_p;
    mm_b     = mm_p;
    idx_dec  = 1'b0;
    set_res  = 1'b0;
    set_err  = 1'b0;
    unique case (st_q)
      IDLE: if (start) st_d = LOAD;
      LOAD: begin
        if (mod_q == '0 || base_q >= mod_q) begin
          st_d    = FIN;
          set_err = 1'b1;
        end else begin
          st_d     = SQR;
          mm_start = 1'b1;
          mm_a     = acc_init;
          mm_b     = acc_init;
        end
      end
      SQR: begin
        if (mm_done) begin
          if (exp_q[idx_q]) begin
            st_d     = MUL;
            mm_start = 1'b1;
            mm_b     = base_q;
          end else if (idx_q == '0) begin
            st_d    = FIN;
            set_res = 1'b1;
          end else begin
            idx_dec  = 1'b1;
            mm_start = 1'b1;
          end
        end
      end
      MUL: begin
        if (mm_done) begin
          if (idx_q == '0) begin
            st_d    = FIN;
            set_res = 1'b1;
          end else begin
            st_d     = SQR;
            idx_dec  = 1'b1;
            mm_start = 1'b1;
          end
        end
      end
      FIN:     st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // State, operand capture, bit index and result/error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      base_q <= '0;
      exp_q  <= '0;
      mod_q  <= '0;
      idx_q  <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      st_q <= st_d;
      if (capture) begin
        base_q <= base;
        exp_q  <= exponent;
        mod_q  <= modulus;
        idx_q  <= IW'(EXP_WIDTH - 1);
        result <= '0;
        error  <= 1'b0;
      end
      if (idx_dec) idx_q <= idx_q - 1'b1;
      if (set_res) result <= mm_p;
      if (set_err) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed + random bench for rsa_modexp at WIDTH=8 and WIDTH=64.
// Results checked against a plain-arithmetic modexp reference.
module tb_rsa_modexp;

  logic clk = 1'b0;
  logic reset;

  logic        start8;
  logic [7:0]  base8, exp8, mod8;
  logic        busy8, done8, err8;
  logic [7:0]  res8;

  logic        start64;
  logic [63:0] base64, exp64, mod64;
  logic        busy64, done64, err64;
  logic [63:0] res64;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rsa_modexp #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .start   (start8),
    .base    (base8),
    .exponent(exp8),
    .modulus (mod8),
    .busy    (busy8),
    .done    (done8),
    .error   (err8),
    .result  (res8)
  );

  rsa_modexp #(.WIDTH(64), .EXP_WIDTH(64)) dut64 (
    .clk     (clk),
    .reset   (reset),
    .start   (start64),
    .base    (base64),
    .exponent(exp64),
    .modulus (mod64),
    .busy    (busy64),
    .done    (done64),
    .error   (err64),
    .result  (res64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: right-to-left binary exponentiation with wide products
  function automatic logic [63:0] mexp(input logic [63:0] b,
                                       input logic [63:0] e,
                                       input logic [63:0] n);
    logic [127:0] r, x, nn;
    nn = {64'd0, n};
    r  = 128'd1 % nn;
    x  = {64'd0, b};
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % nn;
      x = (x * x) % nn;
    end
    return r[63:0];
  endfunction

  function automatic bit get_done(input bit w);
    return w ? done64 : done8;
  endfunction

  function automatic bit get_busy(input bit w);
    return w ? busy64 : busy8;
  endfunction

  function automatic logic [63:0] get_res(input bit w);
    return w ? res64 : {56'd0, res8};
  endfunction

  function automatic bit get_err(input bit w);
    return w ? err64 : err8;
  endfunction

  task automatic drive(input bit w, input bit s, input logic [63:0] b,
                       input logic [63:0] e, input logic [63:0] n);
    if (w) begin
      start64 = s; base64 = b; exp64 = e; mod64 = n;
    end else begin
      start8 = s; base8 = b[7:0]; exp8 = e[7:0]; mod8 = n[7:0];
    end
  endtask

  task automatic run(input string tag, input bit w, input logic [63:0] b,
                     input logic [63:0] e, input logic [63:0] n,
                     input int glitch, input int abort);
    int ew, cyc, lat;
    logic [63:0] exp_r;
    bit exp_e, busy_ok, seen;
    ew    = w ? 64 : 8;
    exp_e = (n == 0) || (b >= n);
    exp_r = exp_e ? 64'd0 : mexp(b, e, n);
    lat   = exp_e ? 2 : 2 + (ew + $countones(e)) * (ew + 1);
    drive(w, 1'b1, b, e, n);
    tick();
    drive(w, 1'b0, ~b, ~e, ~n);
    cyc     = 1;
    busy_ok = 1'b1;
    while (!get_done(w) && cyc < lat + 20) begin
      if (!get_busy(w)) busy_ok = 1'b0;
      if (cyc == abort) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check({tag, ":abort_busy"}, {63'd0, get_busy(w)}, 64'd0);
        check({tag, ":abort_res"}, get_res(w), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < lat + 20; k++) begin
          if (get_done(w)) seen = 1'b1;
          tick();
        end
        check({tag, ":abort_nodone"}, {63'd0, seen}, 64'd0);
        return;
      end
      if (cyc == glitch) drive(w, 1'b1, b ^ 64'd1, e ^ 64'd3, n);
      tick();
      drive(w, 1'b0, ~b, ~e, ~n);
      cyc++;
    end
    check({tag, ":lat"}, 64'(cyc), 64'(lat));
    check({tag, ":busy"}, {63'd0, busy_ok}, 64'd1);
    check({tag, ":err"}, {63'd0, get_err(w)}, {63'd0, exp_e});
    check({tag, ":res"}, get_res(w), exp_r);
    check({tag, ":busy_at_done"}, {63'd0, get_busy(w)}, 64'd0);
    tick();
    check({tag, ":done_pulse"}, {63'd0, get_done(w)}, 64'd0);
    check({tag, ":hold"}, get_res(w), exp_r);
  endtask

  initial begin
    logic [63:0] b, e, n;
    reset = 1'b1;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_err", {63'd0, err8}, 64'd0);
    check("rst_res", {56'd0, res8}, 64'd0);
    check("rst_res64", res64, 64'd0);

    check("ref_7_5_23", mexp(64'd7, 64'd5, 64'd23), 64'd17);
    run("t7_5_23", 1'b0, 64'd7, 64'd5, 64'd23, 0, 0);
    run("t254", 1'b0, 64'd254, 64'd255, 64'd255, 0, 0);
    run("e0", 1'b0, 64'd9, 64'd0, 64'd23, 0, 0);
    run("e0_n1_err", 1'b0, 64'd9, 64'd0, 64'd1, 0, 0);
    run("b0_n1", 1'b0, 64'd0, 64'd0, 64'd1, 0, 0);
    run("b0_n1_e", 1'b0, 64'd0, 64'd77, 64'd1, 0, 0);
    run("bge_n", 1'b0, 64'd200, 64'd13, 64'd100, 0, 0);
    run("n0", 1'b0, 64'd200, 64'd13, 64'd0, 0, 0);
    run("glitch", 1'b0, 64'd7, 64'd5, 64'd23, 20, 0);
    run("abort", 1'b0, 64'd7, 64'd5, 64'd23, 0, 40);
    run("after_abort", 1'b0, 64'd7, 64'd5, 64'd23, 0, 0);
    run("b1_emax", 1'b0, 64'd1, 64'd255, 64'd2, 0, 0);

    for (int i = 0; i < 30; i++) begin
      n = 64'($urandom_range(0, 255));
      if (i % 6 == 0) b = 64'($urandom_range(0, 255));
      else b = (n != 0) ? 64'($urandom % 32'(n)) : 64'd0;
      e = 64'($urandom_range(0, 255));
      run("rnd8", 1'b0, b, e, n, 0, 0);
    end

    for (int i = 0; i < 3; i++) begin
      n = {$urandom, $urandom};
      if (i == 0) n = n | 64'h8000_0000_0000_0001;
      b = {$urandom, $urandom} % n;
      e = {$urandom, $urandom};
      run("rnd64", 1'b1, b, e, n, 0, 0);
    end
    n = {$urandom, $urandom} | 64'hC000_0000_0000_0001;
    b = {$urandom, $urandom} % n;
    run("pub_e", 1'b1, b, 64'd65537, n, 0, 0);
    run("err64", 1'b1, n, 64'd3, n, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
